// File: rtl/spi_master.sv
// SPI master, mode 0, fixed 40-bit frame {wr, 3'b000, addr, wdata}, MSB first.
// Every phase (SETUP/HIGH/LOW/HOLD/GAP) lasts CLK_DIV clk cycles, so CS is
// low for exactly 81*CLK_DIV cycles: SETUP + 40 HIGH + 39 LOW + HOLD.
//
// state | meaning
// IDLE  | waiting for start, CS high
// SETUP | CS low, first MOSI bit presented, SCLK low
// HIGH  | SCLK high, slave and master have sampled
// LOW   | SCLK low, next MOSI bit presented
// HOLD  | 40th falling edge done, CS still low so the slave commits
// GAP   | CS high spacing before the next frame
module spi_master #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0] FRAME_LEN = 6'd40;

  state_t      state_q, state_d;
  logic [7:0]  div_q;
  logic [5:0]  bit_cnt_q;
  logic [39:0] tx_q;
  logic [39:0] rx_q;
  logic        div_tc;
  logic [39:0] frame;

  assign div_tc = (div_q == DIV_LAST);
  assign busy   = (state_q != IDLE);
  // Read frames carry no payload; the slave ignores it anyway.
  assign frame  = {wr, 3'b000, addr, (wr ? wdata : 32'h0)};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start)  state_d = SETUP;
      SETUP: if (div_tc) state_d = HIGH;
      HIGH:  if (div_tc) state_d = (bit_cnt_q == FRAME_LEN) ? HOLD : LOW;
      LOW:   if (div_tc) state_d = HIGH;
      HOLD:  if (div_tc) state_d = GAP;
      GAP:   if (div_tc) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Phase divider: restarts at every phase boundary, parked at 0 in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        div_q <= '0;
    else if (state_q == IDLE || div_tc) div_q <= '0;
    else                              div_q <= div_q + 8'd1;
  end

  // Shift registers and registered SPI pins, updated on phase boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      SPI_CLK   <= 1'b0;
      SPI_CS    <= 1'b1;
      SPI_MOSI  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q      <= frame;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            SPI_CS    <= 1'b0;
            SPI_CLK   <= 1'b0;
            SPI_MOSI  <= frame[39];
          end
        end
        SETUP, LOW: begin
          if (div_tc) begin
            SPI_CLK   <= 1'b1;
            rx_q      <= {rx_q[38:0], SPI_MISO};
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end
        end
        HIGH: begin
          if (div_tc) begin
            SPI_CLK <= 1'b0;
            if (bit_cnt_q != FRAME_LEN) begin
              tx_q     <= {tx_q[38:0], 1'b0};
              SPI_MOSI <= tx_q[38];
            end
          end
        end
        HOLD: begin
          if (div_tc) begin
            SPI_CS   <= 1'b1;
            SPI_MOSI <= 1'b0;
            rdata    <= rx_q[31:0];
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural 40-bit SPI slave with a 16-entry register
// map, a scoreboard queue filled by the stimulus and drained by a monitor on done.
module tb_spi_master;

  localparam int D       = 4;
  localparam int TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] rdata;
  logic        SPI_CLK, SPI_CS, SPI_MOSI;
  logic        SPI_MISO = 1'b0;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [16];
  logic [39:0] s_sh;
  int          s_cnt;
  logic [31:0] s_data;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'hCAFE_0000;
    mem[1] = 32'h1234_5678;
  end

  always @(negedge SPI_CS) begin
    s_cnt    = 0;
    s_sh     = '0;
    SPI_MISO = 1'b0;
  end

  always @(posedge SPI_CLK) begin
    s_sh  = {s_sh[38:0], SPI_MOSI};
    s_cnt = s_cnt + 1;
    if (s_cnt == 8) s_data = mem[s_sh[3:0]];
  end

  always @(negedge SPI_CLK) begin
    if (!SPI_CS && s_cnt >= 8 && s_cnt < 40) SPI_MISO = s_data[39 - s_cnt];
    else SPI_MISO = 1'b0;
  end

  always @(posedge SPI_CS) begin
    if (s_cnt == 40 && s_sh[39]) mem[s_sh[35:32]] = s_sh[31:0];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [39:0] frame;
    logic [31:0] rdata;
    time         t_issue;
  } exp_t;
  exp_t q[$];

  int          rise_cnt = 0, fall_cnt = 0, cs_low_cnt = 0, gap_cnt = 0, cs_falls = 0;
  int          mosi_viol = 0, busy_viol = 0;
  logic [39:0] mosi_sh = '0;
  logic        prev_clk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, gap_armed = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      rise_cnt = 0; fall_cnt = 0; cs_low_cnt = 0; gap_armed = 1'b0;
    end else begin
      if (prev_cs && !SPI_CS) begin
        cs_falls++;
        if (gap_armed) check("cs_gap_min", 64'(gap_cnt >= D), 64'd1);
        gap_armed = 1'b0;
        rise_cnt = 0; fall_cnt = 0; cs_low_cnt = 0; mosi_sh = '0;
        mosi_viol = 0; busy_viol = 0;
      end
      if (!SPI_CS) begin
        cs_low_cnt++;
        if (!busy) busy_viol++;
      end else if (gap_armed) gap_cnt++;
      if (!prev_clk && SPI_CLK) begin
        rise_cnt++;
        mosi_sh = {mosi_sh[38:0], SPI_MOSI};
      end
      if (prev_clk && !SPI_CLK) fall_cnt++;
      if (prev_clk && SPI_CLK && (prev_mosi != SPI_MOSI)) mosi_viol++;
      if (done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected no frame pending");
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rdata", 64'(rdata), 64'(e.rdata));
          check("mosi_frame", 64'(mosi_sh), 64'(e.frame));
          check("sclk_rises", 64'(rise_cnt), 64'd40);
          check("sclk_falls", 64'(fall_cnt), 64'd40);
          check("cs_low_cycles", 64'(cs_low_cnt), 64'(81 * D));
          check("latency", 64'(($time - e.t_issue) / 10), 64'(81 * D + 1));
          check("mosi_while_sclk_high", 64'(mosi_viol), 64'd0);
          check("busy_in_frame", 64'(busy_viol), 64'd0);
          check("busy_after_done", 64'(busy), 64'd1);
        end
        gap_armed = 1'b1;
        gap_cnt   = 0;
      end
    end
    prev_clk  = SPI_CLK;
    prev_cs   = SPI_CS;
    prev_mosi = SPI_MOSI;
  end

  // ---------------- stimulus ----------------
  int frames_issued = 0;

  task automatic wait_idle();
    int n = 0;
    while (busy && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input int hold);
    exp_t e;
    wait_idle();
    wr = w; addr = a; wdata = d; start = 1'b1;
    e.frame   = {w, 3'b000, a, d};
    e.rdata   = exp_rd;
    e.t_issue = $time;
    q.push_back(e);
    frames_issued++;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    check("busy_on_accept", 64'(busy), 64'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(SPI_CS), 64'd1);
    check("rst_sclk", 64'(SPI_CLK), 64'd0);
    check("rst_mosi", 64'(SPI_MOSI), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abort a read at bit 20 with reset.
    issue(1'b0, 4'h1, 32'h0, 32'h0, 1);
    n = 0;
    while (rise_cnt < 20 && n < TIMEOUT) begin @(negedge clk); n++; end
    check("reached_bit20", 64'(rise_cnt >= 20), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_cs", 64'(SPI_CS), 64'd1);
    check("abort_sclk", 64'(SPI_CLK), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    q.delete();
    frames_issued--;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_rdata", 64'(rdata), 64'd0);
    check("abort_no_write", 64'(mem[1]), 64'h1234_5678);
    frames_issued++;  // the aborted frame still produced one CS fall

    // Write, then read with slave data from bit 9.
    issue(1'b1, 4'h3, 32'hDEAD_BEEF, 32'h1000_0003, 1);
    issue(1'b0, 4'h1, 32'h0, 32'h1234_5678, 1);

    // start held 3 cycles and re-pulsed mid-frame: one frame only.
    issue(1'b1, 4'h5, 32'h0BAD_F00D, 32'h1000_0005, 3);
    n = 0;
    while (rise_cnt < 10 && n < TIMEOUT) begin @(negedge clk); n++; end
    start = 1'b1; @(negedge clk); start = 1'b0;

    // Back-to-back: each issue fires on the first cycle busy is low.
    issue(1'b0, 4'h5, 32'h0, 32'h0BAD_F00D, 1);
    issue(1'b0, 4'h3, 32'h0, 32'hDEAD_BEEF, 1);

    // Loopback through the slave register map.
    issue(1'b1, 4'h1, 32'h0000_00A5, 32'h1234_5678, 1);
    wait_idle();
    check("slave_reg1", 64'(mem[1]), 64'h0000_00A5);
    issue(1'b0, 4'h1, 32'h0, 32'h0000_00A5, 1);
    issue(1'b0, 4'h0, 32'h0, 32'hCAFE_0000, 1);

    wait_idle();
    n = 0;
    while (q.size() != 0 && n < TIMEOUT) begin @(negedge clk); n++; end
    check("queue_drained", 64'(q.size()), 64'd0);
    repeat (4 * D) @(negedge clk);
    check("cs_frames", 64'(cs_falls), 64'(frames_issued));
    check("rdata_held", 64'(rdata), 64'hCAFE_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
